ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, directly downstream of the decode stage. It consumes the decoded operation (aluop/alusel, two operands, destination register, write enable) and computes a single-cycle logic, shift or arithmetic result, or runs a 32-cycle iterative divide. It drives the combinational forwarding path back to decode and owns the EX/MEM pipeline latch. During a divide it raises a stall request to the pipeline controller.

---
 rtl/ex_stage_pkg.sv | 53 +++++
 rtl/ex_stage_if.sv | 38 +++
 rtl/ex_stage_div_unit.sv | 107 ++++++++++
 rtl/ex_stage.sv | 118 +++++++++++
 tb/tb_ex_stage.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Pipeline definitions shared by decode and EX: operation encodings, widths,
// reserved constants and the EX/MEM latch payload.
package ex_stage_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned REG_AW         = 5;
  localparam int unsigned ALUOP_W        = 8;
  localparam int unsigned ALUSEL_W       = 3;
  localparam int unsigned DIV_CYCLES_DEF = 32;

  localparam logic [DATA_W-1:0] ZEROWORD   = '0;
  localparam logic [REG_AW-1:0] NOPREGADDR = '0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  typedef enum logic [ALUSEL_W-1:0] {
    RES_NOP   = 3'b000,
    RES_LOGIC = 3'b001,
    RES_SHIFT = 3'b010,
    RES_ARITH = 3'b100,
    RES_DIV   = 3'b101
  } alusel_e;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP  = 8'b0000_0000,
    ALU_SRL  = 8'b0000_0010,
    ALU_SRA  = 8'b0000_0011,
    ALU_DIV  = 8'b0001_1010,
    ALU_DIVU = 8'b0001_1011,
    ALU_ADDU = 8'b0010_0001,
    ALU_SUBU = 8'b0010_0011,
    ALU_AND  = 8'b0010_0100,
    ALU_OR   = 8'b0010_0101,
    ALU_XOR  = 8'b0010_0110,
    ALU_NOR  = 8'b0010_0111,
    ALU_SLT  = 8'b0010_1010,
    ALU_SLTU = 8'b0010_1011,
    ALU_SLL  = 8'b0111_1100
  } aluop_e;

  typedef struct packed {
    logic              wreg;
    logic [REG_AW-1:0] wd;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } exmem_t;

endpackage

// File: rtl/ex_stage_if.sv
// Decode -> EX operation bundle, forwarding path back to decode, stall
// handshake with the pipeline controller and the EX/MEM latch outputs.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [ALUOP_W-1:0]  aluop_i;
  logic [ALUSEL_W-1:0] alusel_i;
  logic [DATA_W-1:0]   reg1_i;
  logic [DATA_W-1:0]   reg2_i;
  logic [REG_AW-1:0]   wd_i;
  logic                wreg_i;
  logic                stall_i;
  logic                flush_i;

  logic                ex_wreg_o;
  logic [REG_AW-1:0]   ex_wd_o;
  logic [DATA_W-1:0]   ex_wdata_o;
  logic                stallreq_o;

  logic                mem_wreg_o;
  logic [REG_AW-1:0]   mem_wd_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic                mem_whilo_o;
  logic [DATA_W-1:0]   mem_hi_o;
  logic [DATA_W-1:0]   mem_lo_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
    input  ex_wreg_o, ex_wd_o, ex_wdata_o, stallreq_o,
    input  mem_wreg_o, mem_wd_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
    output ex_wreg_o, ex_wd_o, ex_wdata_o, stallreq_o,
    output mem_wreg_o, mem_wd_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o
  );
endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider with its own operand copies; signed
// divides run on magnitudes and the signs are restored on the way into DONE.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              abort,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W-1:0]   acc_q;      // {partial remainder, dividend/quotient}
  logic [DATA_W-1:0]     divisor_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic [DATA_W-1:0]     quo_q;
  logic [DATA_W-1:0]     rem_q;

  logic [DATA_W:0]       partial;
  logic [DATA_W+1:0]     diff;
  logic [2*DATA_W-1:0]   acc_step;
  logic [DATA_W-1:0]     a_mag;
  logic [DATA_W-1:0]     b_mag;

  // One shift-subtract step; a borrow means the trial subtraction is discarded.
  always_comb begin
    partial = {acc_q[2*DATA_W-1 -: DATA_W], acc_q[DATA_W-1]};
    diff    = {1'b0, partial} - {2'b00, divisor_q};
    if (diff[DATA_W+1]) begin
      acc_step = {partial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end else begin
      acc_step = {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end
    a_mag = (signed_op && op_a[DATA_W-1]) ? (ZEROWORD - op_a) : op_a;
    b_mag = (signed_op && op_b[DATA_W-1]) ? (ZEROWORD - op_b) : op_b;
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            acc_q     <= {ZEROWORD, a_mag};
            divisor_q <= b_mag;
            neg_quo_q <= signed_op & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            neg_rem_q <= signed_op & op_a[DATA_W-1];
            // Zero divisor short-circuits straight to the architected result.
            if (op_b == ZEROWORD) begin
              state_q <= S_DONE;
              quo_q   <= '1;
              rem_q   <= op_a;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
            state_q <= S_DONE;
            quo_q   <= neg_quo_q ? (ZEROWORD - acc_step[DATA_W-1:0])
                                 : acc_step[DATA_W-1:0];
            rem_q   <= neg_rem_q ? (ZEROWORD - acc_step[2*DATA_W-1 -: DATA_W])
                                 : acc_step[2*DATA_W-1 -: DATA_W];
          end
        end
        S_DONE: begin
          if (!hold) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU, forwarding to decode, iterative divide
// with pipeline stall request, and the EX/MEM pipeline latch.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  logic [DATA_W-1:0] result;
  logic              op_valid;
  logic              sel_div;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem;
  logic              stallreq;
  exmem_t            exmem_q;
  exmem_t            exmem_d;

  assign sel_div = (bus.alusel_i == RES_DIV);

  div_unit #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (sel_div),
    .signed_op (bus.aluop_i == ALU_DIV),
    .abort     (bus.flush_i),
    .op_a      (bus.reg1_i),
    .op_b      (bus.reg2_i),
    .hold      (bus.stall_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Single-cycle result mux; anything not recognised yields 0 and no write.
  always_comb begin
    result   = ZEROWORD;
    op_valid = 1'b0;
    case (bus.alusel_i)
      RES_LOGIC: begin
        op_valid = 1'b1;
        case (bus.aluop_i)
          ALU_OR:  result = bus.reg1_i | bus.reg2_i;
          ALU_AND: result = bus.reg1_i & bus.reg2_i;
          ALU_XOR: result = bus.reg1_i ^ bus.reg2_i;
          ALU_NOR: result = ~(bus.reg1_i | bus.reg2_i);
          default: op_valid = 1'b0;
        endcase
      end
      RES_SHIFT: begin
        op_valid = 1'b1;
        case (bus.aluop_i)
          ALU_SLL: result = bus.reg2_i << bus.reg1_i[4:0];
          ALU_SRL: result = bus.reg2_i >> bus.reg1_i[4:0];
          ALU_SRA: result = DATA_W'($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
          default: op_valid = 1'b0;
        endcase
      end
      RES_ARITH: begin
        op_valid = 1'b1;
        case (bus.aluop_i)
          ALU_ADDU: result = bus.reg1_i + bus.reg2_i;
          ALU_SUBU: result = bus.reg1_i - bus.reg2_i;
          ALU_SLT:  result = DATA_W'($signed(bus.reg1_i) < $signed(bus.reg2_i));
          ALU_SLTU: result = DATA_W'(bus.reg1_i < bus.reg2_i);
          default:  op_valid = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // A flush squashes the divide, so it also withdraws the stall request.
  assign stallreq = ~bus.flush_i & ((sel_div & ~div_busy & ~div_done) | div_busy);

  assign bus.stallreq_o = stallreq;
  assign bus.ex_wreg_o  = bus.wreg_i & op_valid & ~stallreq;
  assign bus.ex_wd_o    = bus.wd_i;
  assign bus.ex_wdata_o = result;

  always_comb begin
    exmem_d = exmem_q;
    if (!bus.stall_i) begin
      if (stallreq) begin
        exmem_d = '0;
      end else begin
        exmem_d.wreg  = bus.wreg_i & op_valid;
        exmem_d.wd    = bus.wd_i;
        exmem_d.wdata = result;
        exmem_d.whilo = sel_div & div_done;
        exmem_d.hi    = (sel_div & div_done) ? div_rem : ZEROWORD;
        exmem_d.lo    = (sel_div & div_done) ? div_quo : ZEROWORD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign bus.mem_wreg_o  = exmem_q.wreg;
  assign bus.mem_wd_o    = exmem_q.wd;
  assign bus.mem_wdata_o = exmem_q.wdata;
  assign bus.mem_whilo_o = exmem_q.whilo;
  assign bus.mem_hi_o    = exmem_q.hi;
  assign bus.mem_lo_o    = exmem_q.lo;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vectors with literal expectations plus a
// cycle-level reference model checked on every falling edge.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int unsigned STALL_AFTER_START = 32;

  logic clk;
  logic rst;
  logic chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  ex_stage_if bus();

  ex_stage #(.DIV_CYCLES(DIV_CYCLES_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b,
                                          output logic gpr);
    logic [31:0] r;
    gpr = 1'b1;
    r   = 32'h0;
    if      (sel == RES_LOGIC && op == ALU_OR)   r = a | b;
    else if (sel == RES_LOGIC && op == ALU_AND)  r = a & b;
    else if (sel == RES_LOGIC && op == ALU_XOR)  r = a ^ b;
    else if (sel == RES_LOGIC && op == ALU_NOR)  r = ~(a | b);
    else if (sel == RES_SHIFT && op == ALU_SLL)  r = b << a[4:0];
    else if (sel == RES_SHIFT && op == ALU_SRL)  r = b >> a[4:0];
    else if (sel == RES_SHIFT && op == ALU_SRA)  r = 32'($signed(b) >>> a[4:0]);
    else if (sel == RES_ARITH && op == ALU_ADDU) r = a + b;
    else if (sel == RES_ARITH && op == ALU_SUBU) r = a - b;
    else if (sel == RES_ARITH && op == ALU_SLT)  r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
    else if (sel == RES_ARITH && op == ALU_SLTU) r = (a < b) ? 32'h1 : 32'h0;
    else gpr = 1'b0;
    return r;
  endfunction

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = 32'(sa / sb);
    r = 32'(sa % sb);
  endfunction

  int          m_wait = 0;     // stall cycles still owed by the running divide
  logic        m_done = 1'b0;  // divide finished, result waiting to be latched
  logic [31:0] m_q = '0, m_r = '0;
  logic        m_wreg = 1'b0, m_whilo = 1'b0;
  logic [4:0]  m_wd = '0;
  logic [31:0] m_wdata = '0, m_hi = '0, m_lo = '0;

  logic        exp_sr, exp_gpr;
  logic [31:0] exp_res, exp_q, exp_r;

  always_comb begin
    exp_sr = 1'b0;
    if (!bus.flush_i && !m_done) exp_sr = (m_wait > 0) || (bus.alusel_i == RES_DIV);
    exp_res = ref_alu(bus.aluop_i, bus.alusel_i, bus.reg1_i, bus.reg2_i, exp_gpr);
    ref_div(bus.reg1_i, bus.reg2_i, bus.aluop_i == ALU_DIV, exp_q, exp_r);
  end

  always @(posedge clk) begin
    if (rst || bus.flush_i) begin
      m_wait <= 0; m_done <= 1'b0;
      m_wreg <= 1'b0; m_wd <= '0; m_wdata <= '0; m_whilo <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else begin
      if (m_done) begin
        if (!bus.stall_i) m_done <= 1'b0;
      end else if (m_wait > 0) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) m_done <= 1'b1;
      end else if (bus.alusel_i == RES_DIV) begin
        m_q <= exp_q;
        m_r <= exp_r;
        if (bus.reg2_i == 32'h0) m_done <= 1'b1;
        else m_wait <= STALL_AFTER_START;
      end
      if (!bus.stall_i) begin
        if (exp_sr) begin
          m_wreg <= 1'b0; m_wd <= '0; m_wdata <= '0; m_whilo <= 1'b0; m_hi <= '0; m_lo <= '0;
        end else begin
          m_wreg  <= bus.wreg_i & exp_gpr;
          m_wd    <= bus.wd_i;
          m_wdata <= exp_res;
          m_whilo <= m_done && (bus.alusel_i == RES_DIV);
          m_hi    <= (m_done && (bus.alusel_i == RES_DIV)) ? m_r : 32'h0;
          m_lo    <= (m_done && (bus.alusel_i == RES_DIV)) ? m_q : 32'h0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stallreq",  32'(bus.stallreq_o), 32'(exp_sr));
      check("ex_wreg",   32'(bus.ex_wreg_o),  32'(bus.wreg_i & exp_gpr & ~exp_sr));
      check("ex_wd",     32'(bus.ex_wd_o),    32'(bus.wd_i));
      check("ex_wdata",  bus.ex_wdata_o,      exp_res);
      check("mem_wreg",  32'(bus.mem_wreg_o), 32'(m_wreg));
      check("mem_wd",    32'(bus.mem_wd_o),   32'(m_wd));
      check("mem_wdata", bus.mem_wdata_o,     m_wdata);
      check("mem_whilo", 32'(bus.mem_whilo_o), 32'(m_whilo));
      check("mem_hi",    bus.mem_hi_o,        m_hi);
      check("mem_lo",    bus.mem_lo_o,        m_lo);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, b;
    logic [4:0]  wd;
    logic        we;
    logic [31:0] exp;
    logic        exp_we;
  } vec_t;

  vec_t vecs[13];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic we);
    bus.aluop_i = op; bus.alusel_i = sel; bus.reg1_i = a; bus.reg2_i = b;
    bus.wd_i = wd; bus.wreg_i = we;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (bus.stallreq_o && n < 100) begin
      n++;
      cyc();
    end
  endtask

  int n;

  initial begin
    vecs[0]  = '{ALU_OR,   RES_LOGIC, 32'h0000_1100, 32'h0000_0011, 5'd5,  1'b1, 32'h0000_1111, 1'b1};
    vecs[1]  = '{ALU_AND,  RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6,  1'b1, 32'h00F0_00F0, 1'b1};
    vecs[2]  = '{ALU_XOR,  RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd7,  1'b1, 32'hF0F0_0F0F, 1'b1};
    vecs[3]  = '{ALU_NOR,  RES_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 5'd8,  1'b1, 32'hFF00_0000, 1'b1};
    vecs[4]  = '{ALU_SLL,  RES_SHIFT, 32'd8,         32'h0000_0001, 5'd9,  1'b1, 32'h0000_0100, 1'b1};
    vecs[5]  = '{ALU_SRL,  RES_SHIFT, 32'd4,         32'h8000_0000, 5'd10, 1'b1, 32'h0800_0000, 1'b1};
    vecs[6]  = '{ALU_SRA,  RES_SHIFT, 32'd4,         32'h8000_0000, 5'd11, 1'b1, 32'hF800_0000, 1'b1};
    vecs[7]  = '{ALU_ADDU, RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0002, 5'd12, 1'b1, 32'h0000_0001, 1'b1};
    vecs[8]  = '{ALU_SUBU, RES_ARITH, 32'h0000_0001, 32'h0000_0002, 5'd13, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{ALU_SLT,  RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd14, 1'b1, 32'h0000_0001, 1'b1};
    vecs[10] = '{ALU_SLTU, RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd15, 1'b1, 32'h0000_0000, 1'b1};
    vecs[11] = '{8'hFF,    RES_LOGIC, 32'h1234_5678, 32'h8765_4321, 5'd16, 1'b1, 32'h0000_0000, 1'b0};
    vecs[12] = '{ALU_NOP,  RES_NOP,   32'h1234_5678, 32'h8765_4321, 5'd17, 1'b1, 32'h0000_0000, 1'b0};

    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    drive(ALU_NOP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    check("rst_mem_whilo", 32'(bus.mem_whilo_o), 32'h0);
    check("rst_stallreq", 32'(bus.stallreq_o), 32'h0);
    rst = 1'b0;
    cyc();

    // Single-cycle operations: same-cycle forwarding, next-cycle latch.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].wd, vecs[i].we);
      #1;
      check($sformatf("ex_wdata_v%0d", i), bus.ex_wdata_o, vecs[i].exp);
      cyc();
      check($sformatf("mem_wdata_v%0d", i), bus.mem_wdata_o, vecs[i].exp);
      check($sformatf("mem_wreg_v%0d", i), 32'(bus.mem_wreg_o), 32'(vecs[i].exp_we));
      check($sformatf("mem_wd_v%0d", i), 32'(bus.mem_wd_o), 32'(vecs[i].wd));
    end

    // Signed divide -7 / 2, then a back-to-back unsigned 100 / 7.
    drive(ALU_DIV, RES_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    #1;
    count_stall(n);
    check("div_stall_cycles", 32'(n), 32'd33);
    cyc();
    check("div_lo", bus.mem_lo_o, 32'hFFFF_FFFD);
    check("div_hi", bus.mem_hi_o, 32'hFFFF_FFFF);
    check("div_whilo", 32'(bus.mem_whilo_o), 32'h1);
    check("div_wreg", 32'(bus.mem_wreg_o), 32'h0);
    drive(ALU_DIVU, RES_DIV, 32'd100, 32'd7, 5'd4, 1'b0);
    #1;
    count_stall(n);
    check("divu_stall_cycles", 32'(n), 32'd33);
    cyc();
    check("divu_lo", bus.mem_lo_o, 32'd14);
    check("divu_hi", bus.mem_hi_o, 32'd2);

    // Divide by zero takes the short path.
    drive(ALU_DIV, RES_DIV, 32'h0000_1234, 32'h0, 5'd4, 1'b0);
    #1;
    count_stall(n);
    check("div0_stall_cycles", 32'(n), 32'd1);
    cyc();
    check("div0_lo", bus.mem_lo_o, 32'hFFFF_FFFF);
    check("div0_hi", bus.mem_hi_o, 32'h0000_1234);
    drive(ALU_NOP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    cyc();

    // Flush in the middle of a divide, then a normal OR.
    drive(ALU_DIVU, RES_DIV, 32'd100, 32'd3, 5'd2, 1'b0);
    repeat (10) cyc();
    check("busy_stallreq", 32'(bus.stallreq_o), 32'h1);
    bus.flush_i = 1'b1;
    #1;
    check("flush_stallreq", 32'(bus.stallreq_o), 32'h0);
    cyc();
    bus.flush_i = 1'b0;
    check("flush_whilo", 32'(bus.mem_whilo_o), 32'h0);
    drive(ALU_OR, RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd9, 1'b1);
    #1;
    check("post_flush_ex_wdata", bus.ex_wdata_o, 32'h0000_00FF);
    cyc();
    check("post_flush_mem_wdata", bus.mem_wdata_o, 32'h0000_00FF);
    check("post_flush_mem_wd", 32'(bus.mem_wd_o), 32'd9);
    repeat (3) cyc();
    check("post_flush_whilo", 32'(bus.mem_whilo_o), 32'h0);

    // Downstream stall held for three cycles while the divider sits in DONE.
    drive(ALU_DIV, RES_DIV, 32'd100, 32'hFFFF_FFF9, 5'd1, 1'b0);
    #1;
    count_stall(n);
    check("sdiv_stall_cycles", 32'(n), 32'd33);
    bus.stall_i = 1'b1;
    repeat (3) begin
      cyc();
      check("held_whilo", 32'(bus.mem_whilo_o), 32'h0);
      check("held_stallreq", 32'(bus.stallreq_o), 32'h0);
    end
    bus.stall_i = 1'b0;
    cyc();
    check("released_whilo", 32'(bus.mem_whilo_o), 32'h1);
    check("released_lo", bus.mem_lo_o, 32'hFFFF_FFF2);
    check("released_hi", bus.mem_hi_o, 32'd2);
    drive(ALU_NOP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    cyc();

    // Reset mid-divide clears a latch that the stall kept non-zero.
    drive(ALU_OR, RES_LOGIC, 32'hA000_0000, 32'h0000_0005, 5'd21, 1'b1);
    cyc();
    bus.stall_i = 1'b1;
    drive(ALU_DIVU, RES_DIV, 32'd50, 32'd5, 5'd0, 1'b0);
    repeat (5) cyc();
    check("pre_rst_mem_wdata", bus.mem_wdata_o, 32'hA000_0005);
    rst = 1'b1;
    drive(ALU_NOP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    cyc();
    rst = 1'b0;
    bus.stall_i = 1'b0;
    check("rst_mid_wdata", bus.mem_wdata_o, 32'h0);
    check("rst_mid_wreg", 32'(bus.mem_wreg_o), 32'h0);
    check("rst_mid_wd", 32'(bus.mem_wd_o), 32'h0);
    check("rst_mid_stallreq", 32'(bus.stallreq_o), 32'h0);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
